// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// Build option: SEQ_TX_PARITY_EN appends an even-parity bit to every frame.
package seq_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Frame length in bits: the data word, plus one parity bit when enabled.
  function automatic int frame_len(input int data_w);
`ifdef SEQ_TX_PARITY_EN
    return data_w + 1;
`else
    return data_w;
`endif
  endfunction

  // Default stimulus word for the 1000 sequence detector.
  localparam logic [3:0] PAT_1000 = 4'b1000;

endpackage

// File: rtl/seq_tx_shreg.sv
// Loadable MSB-first shift register with asynchronous active-low clear.
// Only the MSB leaves the block; zeros are shifted in at the LSB.
module seq_tx_shreg #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load_en,
  input  logic         shift_en,
  input  logic [W-1:0] load_word,
  output logic         msb
);

  logic [W-1:0] sh_reg;

  // Load has priority over shift; reset clears the whole register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sh_reg <= '0;
    end else if (load_en) begin
      sh_reg <= load_word;
    end else if (shift_en) begin
      sh_reg <= {sh_reg[W-2:0], 1'b0};
    end
  end

  assign msb = sh_reg[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a DATA_W-bit word MSB-first, one bit per
// clock, with a forced idle gap after each frame and a one-cycle done pulse.
// Build option: SEQ_TX_PARITY_EN appends an even-parity bit (^data) to each frame.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              out,
  output logic              out_valid,
  output logic              done
);

  localparam int L     = frame_len(DATA_W);
  localparam int CNT_W = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(L);
  localparam logic [3:0]       GAP_FIRST = 4'(GAP_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [3:0]       gap_cnt;
  logic [L-1:0]     frame_word;
  logic             accept;
  logic             shreg_msb;

  // Full frame as it will appear on the line, first bit in the MSB.
`ifdef SEQ_TX_PARITY_EN
  assign frame_word = {data, ^data};
`else
  assign frame_word = data;
`endif

  assign accept = (state == IDLE) && load;

  // The first bit goes straight to the out flop on the accepting edge, so the
  // shift register holds the remaining bits already moved up by one place.
  seq_tx_shreg #(
    .W (L)
  ) u_shreg (
    .clock     (clock),
    .reset_n   (reset_n),
    .load_en   (accept),
    .shift_en  (state == SHIFT),
    .load_word ({frame_word[L-2:0], 1'b0}),
    .msb       (shreg_msb)
  );

  // Control FSM with registered outputs; bit_cnt counts bits already on the line.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      ready     <= 1'b1;
      out       <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          out       <= 1'b0;
          out_valid <= 1'b0;
          ready     <= 1'b1;
          if (load) begin
            state     <= SHIFT;
            out       <= frame_word[L-1];
            out_valid <= 1'b1;
            ready     <= 1'b0;
            bit_cnt   <= CNT_W'(1);
          end
        end
        SHIFT: begin
          if (bit_cnt != LAST_BIT) begin
            out     <= shreg_msb;
            bit_cnt <= bit_cnt + 1'b1;
          end else begin
            // Last bit has been shown for a full cycle: end the frame.
            out       <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b1;
            bit_cnt   <= '0;
            if (GAP_CYCLES > 0) begin
              state   <= GAP;
              gap_cnt <= GAP_FIRST;
            end else begin
              state <= IDLE;
              ready <= 1'b1;
            end
          end
        end
        GAP: begin
          out       <= 1'b0;
          out_valid <= 1'b0;
          if (gap_cnt == 4'd0) begin
            state <= IDLE;
            ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out       <= 1'b0;
          out_valid <= 1'b0;
          ready     <= 1'b1;
        end
      endcase
    end
  end

endmodule
